// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate left/right, binary count or ping-pong bounce,
// advanced once every DIV enabled clock cycles and frozen while enable is low.
module led_pattern_gen #(
  parameter int LED_W = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       switch,
  output logic [LED_W-1:0] led
);

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_COUNT  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [1:0]       mode_q;
  logic             dir_up;
  logic [CNT_W-1:0] cnt;

  function automatic logic [LED_W-1:0] seed_of(input logic [1:0] m);
    case (m)
      MODE_ROTR:  seed_of = {1'b1, {(LED_W-1){1'b0}}};
      MODE_COUNT: seed_of = '0;
      default:    seed_of = LED_W'(1);
    endcase
  endfunction

  function automatic logic [LED_W-1:0] step_led(input logic [1:0] m,
                                                input logic [LED_W-1:0] l,
                                                input logic d);
    case (m)
      MODE_ROTR:  step_led = {l[0], l[LED_W-1:1]};
      MODE_COUNT: step_led = l + LED_W'(1);
      MODE_BOUNCE: begin
        // At an end bit the shift reverses on the same step, so each end is lit once per sweep.
        if (d && l[LED_W-1])     step_led = l >> 1;
        else if (!d && l[0])     step_led = l << 1;
        else if (d)              step_led = l << 1;
        else                     step_led = l >> 1;
      end
      default:    step_led = {l[LED_W-2:0], l[LED_W-1]};
    endcase
  endfunction

  function automatic logic step_dir(input logic [1:0] m,
                                    input logic [LED_W-1:0] l,
                                    input logic d);
    step_dir = d;
    if (m == MODE_BOUNCE) begin
      if (d && l[LED_W-1])  step_dir = 1'b0;
      else if (!d && l[0])  step_dir = 1'b1;
    end
  endfunction

  // Mode reload takes priority over a prescaler-driven step on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led    <= LED_W'(1);
      mode_q <= MODE_ROTL;
      dir_up <= 1'b1;
      cnt    <= '0;
    end else if (enable) begin
      if (switch != mode_q) begin
        mode_q <= switch;
        cnt    <= '0;
        dir_up <= 1'b1;
        led    <= seed_of(switch);
      end else if (cnt == CNT_MAX) begin
        cnt    <= '0;
        led    <= step_led(mode_q, led, dir_up);
        dir_up <= step_dir(mode_q, led, dir_up);
      end else begin
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: an 8-bit/DIV=4 instance for the main
// patterns and a 4-bit/DIV=1 instance for single-cycle stepping.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] switch;
  logic [7:0] led;
  logic       enable1;
  logic [1:0] switch1;
  logic [3:0] led1;

  int checks = 0;
  int passes = 0;

  led_pattern_gen #(.LED_W(8), .DIV(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .switch(switch), .led(led)
  );

  led_pattern_gen #(.LED_W(4), .DIV(1)) u_small (
    .clk(clk), .rst(rst), .enable(enable1), .switch(switch1), .led(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (led !== 8'h01) $display("FAIL reset_async led=%h expected=%h", led, 8'h01);
    else passes++;
    checks++;
    if (led1 !== 4'h1) $display("FAIL reset_async_small led=%h expected=%h", led1, 4'h1);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_rotate_left;
    logic [7:0] exp;
    exp = 8'h01;
    switch = 2'b00;
    enable = 1'b1;
    for (int s = 0; s < 32; s++) begin
      advance(3);
      checks++;
      if (led !== exp) $display("FAIL rotl_hold step=%0d led=%h expected=%h", s, led, exp);
      else passes++;
      exp = {exp[6:0], exp[7]};
      advance(1);
      checks++;
      if (led !== exp) $display("FAIL rotl_step step=%0d led=%h expected=%h", s, led, exp);
      else passes++;
    end
  endtask

  task automatic test_rotate_right;
    logic [7:0] exp;
    switch = 2'b01;
    advance(1);
    checks++;
    if (led !== 8'h80) $display("FAIL rotr_seed led=%h expected=%h", led, 8'h80);
    else passes++;
    exp = 8'h80;
    for (int s = 0; s < 8; s++) begin
      advance(4);
      exp = {exp[0], exp[7:1]};
      checks++;
      if (led !== exp) $display("FAIL rotr_step step=%0d led=%h expected=%h", s, led, exp);
      else passes++;
    end
  endtask

  task automatic test_count;
    logic [7:0] exp;
    switch = 2'b10;
    advance(1);
    checks++;
    if (led !== 8'h00) $display("FAIL count_seed led=%h expected=%h", led, 8'h00);
    else passes++;
    exp = 8'h00;
    for (int s = 0; s < 256; s++) begin
      advance(4);
      exp = exp + 8'h01;
      checks++;
      if (led !== exp) $display("FAIL count_step step=%0d led=%h expected=%h", s, led, exp);
      else passes++;
    end
  endtask

  task automatic test_bounce;
    logic [7:0] seq [15];
    int n80;
    int n01;
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    n80 = 0;
    n01 = 0;
    switch = 2'b11;
    advance(1);
    checks++;
    if (led !== 8'h01) $display("FAIL bounce_seed led=%h expected=%h", led, 8'h01);
    else passes++;
    for (int s = 0; s < 15; s++) begin
      advance(4);
      if (led === 8'h80) n80++;
      if (led === 8'h01) n01++;
      checks++;
      if (led !== seq[s]) $display("FAIL bounce_step step=%0d led=%h expected=%h", s, led, seq[s]);
      else passes++;
    end
    checks++;
    if (n80 !== 1) $display("FAIL bounce_msb_count got=%0d expected=1", n80);
    else passes++;
    checks++;
    if (n01 !== 1) $display("FAIL bounce_lsb_count got=%0d expected=1", n01);
    else passes++;
  endtask

  task automatic test_freeze;
    switch = 2'b10;
    advance(21);
    checks++;
    if (led !== 8'h05) $display("FAIL freeze_setup led=%h expected=%h", led, 8'h05);
    else passes++;
    advance(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      switch = (i >= 3 && i < 7) ? 2'b00 : 2'b10;
      advance(1);
      checks++;
      if (led !== 8'h05) $display("FAIL freeze_hold cycle=%0d led=%h expected=%h", i, led, 8'h05);
      else passes++;
    end
    enable = 1'b1;
    advance(1);
    checks++;
    if (led !== 8'h05) $display("FAIL freeze_resume1 led=%h expected=%h", led, 8'h05);
    else passes++;
    advance(1);
    checks++;
    if (led !== 8'h06) $display("FAIL freeze_resume2 led=%h expected=%h", led, 8'h06);
    else passes++;
  endtask

  task automatic test_reset_mid;
    advance(1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (led !== 8'h01) $display("FAIL reset_mid led=%h expected=%h", led, 8'h01);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b1;
    switch = 2'b00;
    enable = 1'b1;
    advance(3);
    checks++;
    if (led !== 8'h01) $display("FAIL reset_mid_hold led=%h expected=%h", led, 8'h01);
    else passes++;
    advance(1);
    checks++;
    if (led !== 8'h02) $display("FAIL reset_mid_step led=%h expected=%h", led, 8'h02);
    else passes++;
  endtask

  task automatic test_small_bounce;
    logic [3:0] seq [7];
    seq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    switch1 = 2'b11;
    enable1 = 1'b1;
    advance(1);
    checks++;
    if (led1 !== 4'h1) $display("FAIL small_seed led=%h expected=%h", led1, 4'h1);
    else passes++;
    for (int s = 0; s < 7; s++) begin
      advance(1);
      checks++;
      if (led1 !== seq[s]) $display("FAIL small_step step=%0d led=%h expected=%h", s, led1, seq[s]);
      else passes++;
    end
    // Led is 2 moving up: a step would give 4, the rotR reload gives 8.
    switch1 = 2'b01;
    advance(1);
    checks++;
    if (led1 !== 4'h8) $display("FAIL small_reload led=%h expected=%h", led1, 4'h8);
    else passes++;
    advance(1);
    checks++;
    if (led1 !== 4'h4) $display("FAIL small_rotr led=%h expected=%h", led1, 4'h4);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    switch = 2'b00;
    enable1 = 1'b0;
    switch1 = 2'b00;
    test_reset;
    test_rotate_left;
    test_rotate_right;
    test_count;
    test_bounce;
    test_freeze;
    test_reset_mid;
    test_small_bounce;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
